// File: rtl/serial_pkg.sv
// Shared types and default sizing for the FIFO-fed serial transmitter.
package serial_pkg;

   localparam int unsigned DATA_W_DEF       = 4;
   localparam int unsigned CLKS_PER_BIT_DEF = 4;
   localparam int unsigned FRAME_BITS       = DATA_W_DEF + 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

endpackage

// File: rtl/fifo_serial_tx_if.sv
// FIFO read-side bus: pop strobe from the transmitter, head word and empty flag from the FIFO.
interface fifo_serial_tx_if
   import serial_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF
) ();

   logic              rd;
   logic [DATA_W-1:0] r_data;
   logic              empty;

   modport master (output rd, input r_data, input empty);
   modport slave  (input rd, output r_data, output empty);

endinterface

// File: rtl/fifo_serial_tx_bit_timer.sv
// Bit-period timer: bit_done is high during the last clk of every line bit.
module bit_timer #(
   parameter int unsigned CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic restart,
   output logic bit_done
);

   localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             bit_done_q, bit_done_d;

   always_comb begin
      cnt_d      = cnt_q + CNT_W'(1);
      if (restart || bit_done_q) begin
         cnt_d = '0;
      end
      bit_done_d = (cnt_d == LAST);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q      <= '0;
         bit_done_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         bit_done_q <= bit_done_d;
      end
   end

   assign bit_done = bit_done_q;

endmodule

// File: rtl/fifo_serial_tx.sv
// Pops words from a first-word-fall-through FIFO and sends each as start, LSB-first data, stop.
module fifo_serial_tx
   import serial_pkg::*;
#(
   parameter int unsigned DATA_W       = DATA_W_DEF,
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     en,
   fifo_serial_tx_if.master         rd_bus,
   output logic                     tx,
   output logic                     busy
);

   localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

   tx_state_t         state_q, state_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [BIT_W-1:0]  bit_idx_q, bit_idx_d;
   logic              tx_q, tx_d;
   logic              busy_q, busy_d;
   logic              rd_c;
   logic              restart_c;
   logic              bit_done;

   bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
      .clk      (clk),
      .reset    (reset),
      .restart  (restart_c),
      .bit_done (bit_done)
   );

   // Pop is gated by reset so no word is lost while the transmitter is held off.
   assign rd_c = reset & (state_q == IDLE) & en & ~rd_bus.empty;

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_idx_d = bit_idx_q;
      tx_d      = tx_q;
      busy_d    = busy_q;
      restart_c = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (rd_c) begin
               shift_d   = rd_bus.r_data;
               state_d   = START;
               tx_d      = 1'b0;
               busy_d    = 1'b1;
               restart_c = 1'b1;
            end
         end
         START: begin
            if (bit_done) begin
               state_d   = DATA;
               tx_d      = shift_q[0];
               bit_idx_d = '0;
            end
         end
         DATA: begin
            if (bit_done) begin
               if (bit_idx_q == LAST_BIT) begin
                  state_d = STOP;
                  tx_d    = 1'b1;
               end else begin
                  shift_d   = shift_q >> 1;
                  tx_d      = shift_d[0];
                  bit_idx_d = bit_idx_q + BIT_W'(1);
               end
            end
         end
         STOP: begin
            if (bit_done) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         bit_idx_q <= '0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_idx_q <= bit_idx_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
      end
   end

   assign rd_bus.rd = rd_c;
   assign tx        = tx_q;
   assign busy      = busy_q;

endmodule
